// File: rtl/reload_sequencer.sv
// rtl/reload_sequencer.sv - reload-value FIFO feeding a self-reloading counter on each wrap
// Optional feature: RELOAD_SEQ_STICKY_EN (hold last popped value when starved)
module reload_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid_i,
    input  logic [3:0]                 push_val_i,
    output logic                       push_ready_o,
    input  logic [3:0]                 count_i,
    output logic                       load_o,
    output logic [3:0]                 load_val_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       underrun_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STARVED = 2'd2
    } state_t;

    logic [3:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_underrun;
    state_t        r_state;
    state_t        w_state_nxt;

    logic          w_wrap;
    logic          w_push;
    logic          w_pop;
    logic          w_underrun_set;
    logic [3:0]    w_head;

    assign w_wrap       = (count_i == 4'hF);
    assign push_ready_o = (r_level != LW'(DEPTH));
    assign w_push       = push_valid_i && push_ready_o;
    assign w_pop        = w_wrap && (r_level != '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign level_o      = r_level;
    assign underrun_o   = r_underrun;

`ifdef RELOAD_SEQ_STICKY_EN
    logic [3:0] r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 4'h0;
        end else if (w_pop) begin
            r_last <= w_head;
        end
    end

    // Starved wraps are covered by the held value, so they never underrun.
    assign w_underrun_set = 1'b0;
`else
    assign w_underrun_set = w_wrap && (r_level == '0) && (r_state == ST_STARVED);
`endif

    // Storage is left unreset; the level/pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_val_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_underrun_set;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_pop && !w_push && (r_level == LW'(1))) begin
                    w_state_nxt = ST_STARVED;
                end
            end
            ST_STARVED: begin
                if (w_push) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load_o     = 1'b0;
        load_val_o = 4'h0;
        if (r_level != '0) begin
            load_o     = 1'b1;
            load_val_o = w_head;
        end
`ifdef RELOAD_SEQ_STICKY_EN
        if ((r_level == '0) && (r_state == ST_STARVED)) begin
            load_o     = 1'b1;
            load_val_o = r_last;
        end
`endif
    end

endmodule

// File: tb/tb_reload_sequencer.sv
// tb/tb_reload_sequencer.sv - scoreboard bench for reload_sequencer against a queue model
module tb_reload_sequencer;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef RELOAD_SEQ_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push_valid_i = 1'b0;
    logic [3:0]    push_val_i = 4'h0;
    logic          push_ready_o;
    logic [3:0]    count_i = 4'h0;
    logic          load_o;
    logic [3:0]    load_val_o;
    logic [LW-1:0] level_o;
    logic          underrun_o;

    reload_sequencer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .push_valid_i (push_valid_i),
        .push_val_i   (push_val_i),
        .push_ready_o (push_ready_o),
        .count_i      (count_i),
        .load_o       (load_o),
        .load_val_o   (load_val_o),
        .level_o      (level_o),
        .underrun_o   (underrun_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       ready;
        bit       load;
        int       val;
        int       level;
        bit       und;
    } exp_t;

    exp_t exp_q[$];
    int   model_q[$];
    bit   ever_popped;
    bit   pend_und;
    int   last_val;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("push_ready", int'(push_ready_o), int'(e.ready));
            chk("load",       int'(load_o),       int'(e.load));
            chk("load_val",   int'(load_val_o),   e.val);
            chk("level",      int'(level_o),      e.level);
            chk("underrun",   int'(underrun_o),   int'(e.und));
        end
    end

    task automatic model_reset();
        model_q.delete();
        ever_popped = 1'b0;
        pend_und    = 1'b0;
        last_val    = 0;
    endtask

    // One clock cycle: drive inputs, record what the outputs must be, advance the model.
    task automatic cycle(input bit v, input int val, input int cnt);
        exp_t e;
        bit   starved;
        bit   wrap;
        bit   acc;
        @(posedge clk);
        #1;
        push_valid_i = v;
        push_val_i   = 4'(val);
        count_i      = 4'(cnt);
        starved  = (model_q.size() == 0) && ever_popped;
        e.ready  = (model_q.size() != DEPTH);
        e.level  = model_q.size();
        e.und    = pend_und;
        if (model_q.size() != 0) begin
            e.load = 1'b1;
            e.val  = model_q[0];
        end else if (STICKY && starved) begin
            e.load = 1'b1;
            e.val  = last_val;
        end else begin
            e.load = 1'b0;
            e.val  = 0;
        end
        exp_q.push_back(e);
        wrap     = (cnt == 15);
        acc      = v && e.ready;
        pend_und = wrap && (model_q.size() == 0) && ever_popped && !STICKY;
        if (wrap && model_q.size() != 0) begin
            last_val    = model_q.pop_front();
            ever_popped = 1'b1;
        end
        if (acc) model_q.push_back(val & 15);
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        push_valid_i = 1'b0;
        count_i = 4'h0;
        #1;
        chk("rst_level",    int'(level_o),      0);
        chk("rst_load",     int'(load_o),       0);
        chk("rst_load_val", int'(load_val_o),   0);
        chk("rst_underrun", int'(underrun_o),   0);
        chk("rst_ready",    int'(push_ready_o), 1);
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Three pushes then three isolated wraps.
        cycle(1, 3, 0); cycle(1, 7, 0); cycle(1, 10, 0);
        cycle(0, 0, 15); cycle(0, 0, 0);
        cycle(0, 0, 15); cycle(0, 0, 0);
        cycle(0, 0, 15); cycle(0, 0, 0);
        // Empty after pop: wrap must underrun (or hold last value when sticky).
        cycle(0, 0, 15); cycle(0, 0, 15); cycle(0, 0, 0); cycle(0, 0, 0);

        // Fill past full; extra offers ignored.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, i + 1, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 15);
        cycle(0, 0, 0);

        // Simultaneous push and pop at level 1.
        cycle(1, 9, 0);
        cycle(1, 5, 15);
        cycle(0, 0, 0);
        cycle(0, 0, 15);
        cycle(0, 0, 0);

        // Wrap straight out of reset stays quiet.
        do_reset();
        cycle(0, 0, 15); cycle(0, 0, 15); cycle(0, 0, 0);

        // Reset with three entries stored discards them.
        cycle(1, 1, 0); cycle(1, 2, 0); cycle(1, 3, 0); cycle(0, 0, 0);
        do_reset();
        cycle(0, 0, 15); cycle(0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            bit v;
            int cnt;
            if ($urandom_range(0, 399) == 0) do_reset();
            v   = ($urandom_range(0, 99) < 55);
            cnt = ($urandom_range(0, 2) == 0) ? 15 : int'($urandom_range(0, 14));
            cycle(v, int'($urandom_range(0, 15)), cnt);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
